// File: rtl/sha1_pkg.sv
// sha1_pkg: shared SHA-1 types, constants and round helpers for the multi-channel engine
package sha1_pkg;
  typedef logic [31:0] uint;
  typedef struct packed { uint a; uint b; uint c; uint d; uint e; } sha1_st_t;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, FINAL, DRAIN} state_t;
  localparam uint IV0 = 32'h67452301;
  localparam uint IV1 = 32'hefcdab89;
  localparam uint IV2 = 32'h98badcfe;
  localparam uint IV3 = 32'h10325476;
  localparam uint IV4 = 32'hc3d2e1f0;
  localparam uint K0 = 32'h5a827999;
  localparam uint K1 = 32'h6ed9eba1;
  localparam uint K2 = 32'h8f1bbcdc;
  localparam uint K3 = 32'hca62c1d6;
  localparam sha1_st_t IV = {IV0, IV1, IV2, IV3, IV4};
  function automatic uint f0(input uint b, input uint c, input uint d);
    return (b & c) | (~b & d);
  endfunction
  function automatic uint f1(input uint b, input uint c, input uint d);
    return b ^ c ^ d;
  endfunction
  function automatic uint f2(input uint b, input uint c, input uint d);
    return (b & c) | (b & d) | (c & d);
  endfunction
  function automatic uint rol1(input uint x);
    return {x[30:0], x[31]};
  endfunction
  function automatic uint rol5(input uint x);
    return {x[26:0], x[31:27]};
  endfunction
  function automatic uint rol30(input uint x);
    return {x[1:0], x[31:2]};
  endfunction
endpackage

// File: rtl/sha1_msg_sched.sv
// sha1_msg_sched: per-channel 16-word circular message schedule with in-place W(t) expansion
module sha1_msg_sched
  import sha1_pkg::*;
#(
  parameter int NCHAN = 4,
  parameter int CHW   = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ld_en,
  input  logic           run_en,
  input  logic [CHW-1:0] ch,
  input  logic [6:0]     idx,
  input  logic [31:0]    ld_data,
  output logic [31:0]    w
);
  uint ring_q [NCHAN][16];
  uint ring_d [NCHAN][16];
  logic [3:0] s;
  // W(t) comes straight from the ring for t<16, otherwise expanded and written over W(t-16)
  always_comb begin
    s = idx[3:0];
    w = idx < 7'd16 ? ring_q[ch][s]
      : rol1(ring_q[ch][s + 4'd13] ^ ring_q[ch][s + 4'd8] ^ ring_q[ch][s + 4'd2] ^ ring_q[ch][s]);
    ring_d = ring_q;
    if (ld_en) ring_d[ch][s] = ld_data;
    if (run_en) ring_d[ch][s] = w;
  end
  // ring storage
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NCHAN; i++)
        for (int j = 0; j < 16; j++) ring_q[i][j] <= '0;
    end else ring_q <= ring_d;
endmodule

// File: rtl/sha1_mchan_engine.sv
// sha1_mchan_engine: NCHAN-way round-robin SHA-1 block engine; SHA1_MATCH_EN adds digest match compare
module sha1_mchan_engine
  import sha1_pkg::*;
#(
  parameter int NCHAN = 4,
  localparam int CHW = NCHAN > 1 ? $clog2(NCHAN) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [31:0]    in_data,
  input  logic           in_first,
`ifdef SHA1_MATCH_EN
  input  logic [159:0]   match_target,
  input  logic [159:0]   match_mask,
  output logic           out_match,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [CHW-1:0] out_chan,
  output logic [159:0]   out_digest
);
  state_t state_q, state_d;
  logic rdy_q, rdy_d, beat, ch_last;
  logic [CHW-1:0] ch_q, ch_d, ch_nx;
  logic [6:0] idx_q, idx_d;
  sha1_st_t chain_q [NCHAN];
  sha1_st_t chain_d [NCHAN];
  sha1_st_t work_q [NCHAN];
  sha1_st_t work_d [NCHAN];
  logic out_valid_q, out_valid_d;
  logic [CHW-1:0] out_chan_q, out_chan_d;
  logic [159:0] out_digest_q, out_digest_d;
  sha1_st_t cur, nxt;
  uint f, k, w;

  sha1_msg_sched #(.NCHAN(NCHAN), .CHW(CHW)) u_sched (
    .clk(clk), .rst_n(rst_n), .ld_en(beat), .run_en(state_q == RUN),
    .ch(ch_q), .idx(idx_q), .ld_data(in_data), .w(w)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;

  // next state: load 16*NCHAN beats, run 80*NCHAN rounds, one finalize cycle, drain NCHAN digests
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = beat ? LOAD : IDLE;
      LOAD:    state_d = beat && idx_q == 7'd15 && ch_last ? RUN : LOAD;
      RUN:     state_d = idx_q == 7'd79 && ch_last ? FINAL : RUN;
      FINAL:   state_d = DRAIN;
      DRAIN:   state_d = out_valid_q && out_ready && ch_last ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end

  // outputs; in_ready is held off until the first edge after reset release
  always_comb begin
    in_ready   = rdy_q && (state_q == IDLE || state_q == LOAD);
    out_valid  = out_valid_q;
    out_chan   = out_chan_q;
    out_digest = out_digest_q;
`ifdef SHA1_MATCH_EN
    out_match  = out_valid_q && (((out_digest_q ^ match_target) & match_mask) == '0);
`endif
  end

  // one SHA-1 round; round 0 of each channel starts from its chaining value
  always_comb begin
    cur = idx_q == 7'd0 ? chain_q[ch_q] : work_q[ch_q];
    f = idx_q < 7'd20 ? f0(cur.b, cur.c, cur.d)
      : (idx_q >= 7'd40 && idx_q < 7'd60) ? f2(cur.b, cur.c, cur.d) : f1(cur.b, cur.c, cur.d);
    k = idx_q < 7'd20 ? K0 : idx_q < 7'd40 ? K1 : idx_q < 7'd60 ? K2 : K3;
    nxt = {rol5(cur.a) + f + cur.e + k + w, cur.a, rol30(cur.b), cur.c, cur.d};
  end

  // counters, per-channel working/chaining state and digest output registers
  always_comb begin
    beat = in_valid && in_ready;
    ch_last = ch_q == CHW'(NCHAN - 1);
    ch_nx = ch_q + 1'b1;
    rdy_d = 1'b1;
    ch_d = ch_q;
    idx_d = idx_q;
    chain_d = chain_q;
    work_d = work_q;
    out_valid_d = out_valid_q;
    out_chan_d = out_chan_q;
    out_digest_d = out_digest_q;
    if (beat) begin
      if (idx_q == 7'd0 && in_first) chain_d[ch_q] = IV;
      idx_d = idx_q == 7'd15 ? 7'd0 : idx_q + 7'd1;
      ch_d = idx_q != 7'd15 ? ch_q : ch_last ? '0 : ch_nx;
    end
    if (state_q == RUN) begin
      work_d[ch_q] = nxt;
      ch_d = ch_last ? '0 : ch_nx;
      idx_d = !ch_last ? idx_q : idx_q == 7'd79 ? 7'd0 : idx_q + 7'd1;
    end
    if (state_q == FINAL)
      for (int i = 0; i < NCHAN; i++)
        chain_d[i] = {chain_q[i].a + work_q[i].a, chain_q[i].b + work_q[i].b,
                      chain_q[i].c + work_q[i].c, chain_q[i].d + work_q[i].d,
                      chain_q[i].e + work_q[i].e};
    if (state_q == DRAIN) begin
      if (!out_valid_q) begin
        out_valid_d = 1'b1;
        out_chan_d = ch_q;
        out_digest_d = chain_q[ch_q];
      end else if (out_ready) begin
        out_valid_d = !ch_last;
        ch_d = ch_last ? '0 : ch_nx;
        out_chan_d = ch_last ? out_chan_q : ch_nx;
        out_digest_d = ch_last ? out_digest_q : chain_q[ch_nx];
      end
    end
  end

  // datapath registers; reset restores IV chaining for every channel
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rdy_q <= 1'b0;
      ch_q <= '0;
      idx_q <= '0;
      chain_q <= '{default: IV};
      work_q <= '{default: '0};
      out_valid_q <= 1'b0;
      out_chan_q <= '0;
      out_digest_q <= '0;
    end else begin
      rdy_q <= rdy_d;
      ch_q <= ch_d;
      idx_q <= idx_d;
      chain_q <= chain_d;
      work_q <= work_d;
      out_valid_q <= out_valid_d;
      out_chan_q <= out_chan_d;
      out_digest_q <= out_digest_d;
    end
endmodule
